// File: rtl/line_point_counter_pkg.sv
// -----------------------------------------------------------------------------
// line_point_counter_pkg
// Shared definitions for line_point_counter:
//   - state_e       : controller state encoding (6 used codes of 3 bits)
//   - default_word  : reset-time contents of the coefficient/point memory
// Optional feature macro used by the top: LINE_POINT_COUNTER_WR_PORT_EN
// -----------------------------------------------------------------------------
package line_point_counter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_Y = 3'd2,
        ST_CALC   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_HOLD   = 3'd5
    } state_e;

    // Word i of the reset table holds i; the caller truncates to its data
    // width, which gives i mod 2^DATA_W.
    function automatic int default_word(input int idx);
        return idx;
    endfunction

endpackage : line_point_counter_pkg

// File: rtl/line_point_counter.sv
// -----------------------------------------------------------------------------
// line_point_counter
// Walks a DEPTH-word memory of (x,y) pairs and counts how many satisfy
// (K*x + y) mod 2^DATA_W == T. Each pair takes four cycles
// (LOAD_X, LOAD_Y, CALC, CHECK); the result is released from HOLD only once
// start is low, at which point punti_retta updates and done pulses.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   run request (IDLE) / result-release level (HOLD)
//   coef_k       in   slope K, latched when a run is accepted
//   target       in   constant T, latched when a run is accepted
//   wr_en        in   memory write enable     (LINE_POINT_COUNTER_WR_PORT_EN)
//   wr_addr      in   memory write address    (LINE_POINT_COUNTER_WR_PORT_EN)
//   wr_data      in   memory write data       (LINE_POINT_COUNTER_WR_PORT_EN)
//   punti_retta  out  number of points on the line from the last run
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse when punti_retta updates
//
// Configuration: define LINE_POINT_COUNTER_WR_PORT_EN to add the write port;
// without it the memory only ever holds the reset table.
// -----------------------------------------------------------------------------
module line_point_counter
    import line_point_counter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH/2+1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_W-1:0]        coef_k,
    input  logic [DATA_W-1:0]        target,
`ifdef LINE_POINT_COUNTER_WR_PORT_EN
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
`endif
    output logic [CNT_W-1:0]         punti_retta,
    output logic                     busy,
    output logic                     done
);

    localparam int MAR_W = $clog2(DEPTH);
    localparam logic [MAR_W-1:0] MAR_LAST = MAR_W'(DEPTH-1);

    state_e              state_q, state_d;
    logic [MAR_W-1:0]    mar_q,   mar_d;
    logic [DATA_W-1:0]   x_q,     x_d;
    logic [DATA_W-1:0]   y_q,     y_d;
    logic [DATA_W-1:0]   acc_q,   acc_d;
    logic [DATA_W-1:0]   k_q,     k_d;
    logic [DATA_W-1:0]   t_q,     t_d;
    logic [CNT_W-1:0]    cont_q,  cont_d;
    logic [CNT_W-1:0]    res_q,   res_d;
    logic                done_q,  done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign punti_retta = res_q;

    // NOTE: the memory is reset like any other register because its reset
    // contents are functional (the default point table), not just a clean
    // start; this forces a flop array rather than an inferred RAM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(default_word(i));
            end
        end
`ifdef LINE_POINT_COUNTER_WR_PORT_EN
        else if (wr_en && !busy) begin
            mem_q[wr_addr] <= wr_data;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            t_q     <= '0;
            cont_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            t_q     <= t_d;
            cont_q  <= cont_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value before the case so no
        // path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        mar_d   = mar_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        k_d     = k_q;
        t_d     = t_q;
        cont_d  = cont_q;
        res_d   = res_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d     = coef_k;
                    t_d     = target;
                    cont_d  = '0;
                    mar_d   = '0;
                    state_d = ST_LOAD_X;
                end
            end
            ST_LOAD_X: begin
                x_d     = mem_q[mar_q];
                mar_d   = mar_q + MAR_W'(1);
                state_d = ST_LOAD_Y;
            end
            ST_LOAD_Y: begin
                y_d     = mem_q[mar_q];
                state_d = ST_CALC;
            end
            ST_CALC: begin
                // Product and sum are evaluated at DATA_W bits: mod 2^DATA_W.
                acc_d   = k_q * x_q + y_q;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // At most DEPTH/2 increments per run, which CNT_W always holds.
                if (acc_q == t_q) begin
                    cont_d = cont_q + CNT_W'(1);
                end
                if (mar_q == MAR_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    mar_d   = mar_q + MAR_W'(1);
                    state_d = ST_LOAD_X;
                end
            end
            ST_HOLD: begin
                // The result is only published once the requester drops start.
                if (!start) begin
                    res_d   = cont_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : line_point_counter

// File: tb/tb_line_point_counter.sv
// -----------------------------------------------------------------------------
// tb_line_point_counter
// Directed bench for line_point_counter (DATA_W=8, DEPTH=16). Expected counts
// come from a reference model of the point memory and are queued when a run
// starts, then popped and compared when done pulses.
// Define LINE_POINT_COUNTER_WR_PORT_EN to also exercise the write port.
// -----------------------------------------------------------------------------
module tb_line_point_counter;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;

    logic              clock;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] coef_k;
    logic [DATA_W-1:0] target;
    logic [CNT_W-1:0]  punti_retta;
    logic              busy;
    logic              done;
`ifdef LINE_POINT_COUNTER_WR_PORT_EN
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
`endif

    line_point_counter #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .coef_k      (coef_k),
        .target      (target),
`ifdef LINE_POINT_COUNTER_WR_PORT_EN
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`endif
        .punti_retta (punti_retta),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    int          sb_q[$];
    logic [7:0]  model_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'(i);
    endtask

    function automatic int model_count(input logic [7:0] k, input logic [7:0] t);
        int         cnt = 0;
        logic [7:0] acc;
        for (int p = 0; p < DEPTH/2; p++) begin
            acc = k * model_mem[2*p] + model_mem[2*p+1];
            if (acc == t) cnt++;
        end
        return cnt;
    endfunction

    // Waits (bounded) for done; lat counts cycles after the accept edge.
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Pulses start for one cycle; returns just after the accept edge.
    task automatic pulse_start(input logic [7:0] k, input logic [7:0] t);
        coef_k = k;
        target = t;
        start  = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
    endtask

    task automatic pop_and_check(input string tag);
        int exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
        check(tag, {28'd0, punti_retta}, exp);
        @(posedge clock); #1;
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_run(input string tag, input logic [7:0] k, input logic [7:0] t,
                          output int lat);
        sb_q.push_back(model_count(k, t));
        pulse_start(k, t);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        // Inputs other than the HOLD start level are ignored while busy.
        coef_k = ~k;
        target = t + 8'd3;
        wait_done(200, lat);
        pop_and_check(tag);
    endtask

    initial begin
        int lat;
        int done_cnt;
        logic [7:0] rk, rt;
        int p;

        start  = 1'b0;
        coef_k = '0;
        target = '0;
`ifdef LINE_POINT_COUNTER_WR_PORT_EN
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
`endif
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", {28'd0, punti_retta}, 32'd0);
        check("rst_busy",   {31'd0, busy},        32'd0);
        check("rst_done",   {31'd0, done},        32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // K=1, T=1: only pair (0,1) matches; done 33 cycles after accept.
        do_run("k1_t1", 8'd1, 8'd1, lat);
        check("k1_t1_latency", lat, 32'd33);

        // K=255, T=1: -x + (x+1) = 1 for every pair.
        do_run("k255_t1", 8'd255, 8'd1, lat);

        // Hold start high: block parks in HOLD without done until start drops.
        sb_q.push_back(model_count(8'd1, 8'd1));
        coef_k = 8'd1;
        target = 8'd1;
        start  = 1'b1;
        @(posedge clock); #1;
        done_cnt = 0;
        for (int c = 0; c < 32 + 50; c++) begin
            @(posedge clock); #1;
            if (done) done_cnt++;
        end
        check("hold_no_done",  done_cnt, 32'd0);
        check("hold_busy",     {31'd0, busy}, 32'd1);
        check("hold_result",   {28'd0, punti_retta}, 32'd8);
        start = 1'b0;
        @(posedge clock); #1;
        check("hold_release_done", {31'd0, done}, 32'd1);
        pop_and_check("hold_release");

        // K=0, T=0: y is never 0 in the default table.
        do_run("k0_t0", 8'd0, 8'd0, lat);

        // Reset ten cycles into a run aborts it with no done.
        sb_q.push_back(model_count(8'd255, 8'd1));
        pulse_start(8'd255, 8'd1);
        repeat (9) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy",   {31'd0, busy},        32'd0);
        check("abort_result", {28'd0, punti_retta}, 32'd0);
        check("abort_done",   {31'd0, done},        32'd0);
        void'(sb_q.pop_front());
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (done || busy) done_cnt++;
        end
        check("abort_quiet", done_cnt, 32'd0);

        do_run("post_abort", 8'd255, 8'd1, lat);

        // Randomised slope with a target guaranteed to hit at least one pair.
        rk = 8'($urandom_range(0, 255));
        p  = $urandom_range(0, DEPTH/2 - 1);
        rt = rk * model_mem[2*p] + model_mem[2*p+1];
        do_run("random", rk, rt, lat);

`ifdef LINE_POINT_COUNTER_WR_PORT_EN
        // Idle write of mem[1]=0 turns pair (0,1) into (0,0): one fewer match.
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'd0;
        @(posedge clock); #1;
        wr_en = 1'b0;
        model_mem[1] = 8'd0;
        do_run("wr_idle", 8'd255, 8'd1, lat);
        check("wr_idle_count", model_count(8'd255, 8'd1), 32'd7);

        // A write issued while busy is dropped.
        sb_q.push_back(model_count(8'd255, 8'd1));
        pulse_start(8'd255, 8'd1);
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'd0;
        @(posedge clock); #1;
        wr_en = 1'b0;
        wait_done(200, lat);
        pop_and_check("wr_busy_run");
        do_run("wr_busy_after", 8'd255, 8'd1, lat);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_line_point_counter
